// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with integrated baud timer.
// Frame: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop bits.
module uart_tx_param #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_par
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0] StopLast = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  assign bit_end = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (i_valid) begin
          state_d = StStart;
          shift_d = i_data;
          par_d   = (PARITY == 1) ? ~^i_data : ^i_data;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == DataLast) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? StParity : StStop;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == StopLast) begin
            idx_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    o_tx = 1'b1;
    unique case (state_q)
      StStart:  o_tx = 1'b0;
      StData:   o_tx = shift_q[0];
      StParity: o_tx = par_q;
      default:  o_tx = 1'b1;
    endcase
  end

  assign o_ready = (state_q == StIdle);
  assign o_busy  = (state_q != StIdle);
  assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances (8N1, 8E2, 8O2, 5N1) at 4 clocks per bit.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] valid;
  logic [7:0] dat [3];
  logic [4:0] d5;
  logic [3:0] tx, ready, busy, done;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_clk(clk), .i_rst(rst), .i_data(dat[0]), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0])
  );
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_8e2 (
    .i_clk(clk), .i_rst(rst), .i_data(dat[1]), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1])
  );
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_8o2 (
    .i_clk(clk), .i_rst(rst), .i_data(dat[2]), .i_valid(valid[2]),
    .o_ready(ready[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2])
  );
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_5n1 (
    .i_clk(clk), .i_rst(rst), .i_data(d5), .i_valid(valid[3]),
    .o_ready(ready[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_done(done[3])
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load(input int u, input int v);
    if (u == 3) d5 = v[4:0];
    else dat[u] = v[7:0];
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first start-bit cycle.
  task automatic accept(input int u, input int v, input bit keep);
    load(u, v);
    valid[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!keep) valid[u] = 1'b0;
    chk("accept_ready", int'(ready[u]), 0);
  endtask

  // exp lists line levels in transmit order; each bit is held 4 cycles.
  task automatic send_bits(input int u, input string exp, input string tag, input bit disturb);
    for (int b = 0; b < exp.len(); b++) begin
      for (int c = 0; c < 4; c++) begin
        chk({tag, "_tx"}, int'(tx[u]), (exp[b] == "1") ? 1 : 0);
        chk({tag, "_busy"}, int'(busy[u]), 1);
        chk({tag, "_done"}, int'(done[u]), 0);
        if (disturb) begin
          if (b == exp.len() - 1 && c == 3) begin
            valid[u] = 1'b0;
          end else begin
            valid[u] = 1'($urandom_range(0, 1));
            load(u, int'($urandom));
          end
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic check_end(input int u, input string tag);
    chk({tag, "_end_done"}, int'(done[u]), 1);
    chk({tag, "_end_ready"}, int'(ready[u]), 1);
    chk({tag, "_end_tx"}, int'(tx[u]), 1);
    chk({tag, "_end_busy"}, int'(busy[u]), 0);
  endtask

  initial begin
    rst   = 1'b1;
    valid = 4'hF;
    for (int i = 0; i < 3; i++) dat[i] = 8'h00;
    d5 = 5'h00;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", int'(tx), 15);
      chk("rst_ready", int'(ready), 15);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
    end
    rst   = 1'b0;
    valid = 4'h0;
    @(negedge clk);
    chk("post_rst_ready", int'(ready), 15);
    chk("post_rst_tx", int'(tx), 15);

    accept(0, 'h55, 1'b0);
    send_bits(0, "0101010101", "8n1_55", 1'b0);
    check_end(0, "8n1_55");
    @(negedge clk);
    chk("8n1_done_once", int'(done[0]), 0);

    accept(1, 'h07, 1'b0);
    send_bits(1, "011100000111", "8e2_07", 1'b0);
    check_end(1, "8e2_07");
    @(negedge clk);

    accept(2, 'h07, 1'b0);
    send_bits(2, "011100000011", "8o2_07", 1'b0);
    check_end(2, "8o2_07");
    @(negedge clk);

    accept(3, 'h13, 1'b0);
    send_bits(3, "0110011", "5n1_13", 1'b0);
    check_end(3, "5n1_13");
    @(negedge clk);

    // Back-to-back: valid held high across the frame boundary.
    accept(0, 'hA5, 1'b1);
    load(0, 'h3C);
    send_bits(0, "0101001011", "b2b_a5", 1'b0);
    check_end(0, "b2b_a5");
    @(negedge clk);
    valid[0] = 1'b0;
    chk("b2b_ready_low", int'(ready[0]), 0);
    send_bits(0, "0001111001", "b2b_3c", 1'b0);
    check_end(0, "b2b_3c");
    @(negedge clk);
    chk("b2b_done_once", int'(done[0]), 0);

    // Inputs toggled mid-frame must not disturb the frame in flight.
    accept(0, 'hA5, 1'b0);
    send_bits(0, "0101001011", "dist_a5", 1'b1);
    check_end(0, "dist_a5");
    @(negedge clk);
    chk("dist_no_restart", int'(ready[0]), 1);

    // Reset during data bit 3 (cycles 16..19 of the frame).
    accept(0, 'h00, 1'b0);
    repeat (17) @(negedge clk);
    chk("pre_rst_tx", int'(tx[0]), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx", int'(tx[0]), 1);
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_ready", int'(ready[0]), 1);
    repeat (8) begin
      chk("abort_no_done", int'(done[0]), 0);
      @(negedge clk);
    end
    accept(0, 'h3C, 1'b0);
    send_bits(0, "0001111001", "after_rst_3c", 1'b0);
    check_end(0, "after_rst_3c");
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
